// File: rtl/enc8to3_seq.sv
// Sequential 8-to-3 encoder: captures a request vector and hands out the index
// of each set bit, one per valid/ready handshake, in a fixed priority order.
module enc8to3_seq #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   input  logic [7:0] in,
   input  logic       ready,
   output logic [2:0] out,
   output logic       valid,
   output logic       last,
   output logic       busy,
   output logic       zero,
   output logic [3:0] cnt
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   logic [0:0] r_state;
   logic [7:0] r_pend;
   logic [2:0] r_out;
   logic       r_zero;

   logic       w_send;
   logic       w_fire;
   logic       w_accept;
   logic [7:0] w_clear;
   logic [7:0] w_idx_src;
   logic [2:0] w_idx;
   logic [3:0] w_cnt;

   assign w_send   = (r_state == S_SEND);
   assign w_fire   = w_send && en && ready;
   assign w_accept = !w_send && en && load;
   // r_out always names the priority bit of r_pend while sending, so it is the bit to retire
   assign w_clear   = r_pend & ~(8'b1 << r_out);
   assign w_idx_src = w_send ? w_clear : in;

   generate
      if (MSB_FIRST) begin : g_msb
         always_comb begin
            w_idx = 3'd0;
            for (int i = 0; i < 8; i++)
               if (w_idx_src[i]) w_idx = 3'(i);
         end
      end else begin : g_lsb
         always_comb begin
            w_idx = 3'd0;
            for (int i = 7; i >= 0; i--)
               if (w_idx_src[i]) w_idx = 3'(i);
         end
      end
   endgenerate

   always_comb begin
      w_cnt = 4'd0;
      for (int i = 0; i < 8; i++)
         w_cnt = w_cnt + 4'(r_pend[i]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pend  <= 8'h00;
         r_out   <= 3'd0;
         r_zero  <= 1'b0;
      end else begin
         r_zero <= w_accept && (in == 8'h00);
         if (w_accept && (in != 8'h00)) begin
            r_state <= S_SEND;
            r_pend  <= in;
            r_out   <= w_idx;
         end else if (w_fire) begin
            r_pend <= w_clear;
            // out keeps the final index once the vector drains
            if (w_clear == 8'h00)
               r_state <= S_IDLE;
            else
               r_out <= w_idx;
         end
      end
   end

   assign out   = r_out;
   assign valid = w_send && en;
   assign last  = valid && (w_cnt == 4'd1);
   assign busy  = w_send;
   assign zero  = r_zero;
   assign cnt   = w_cnt;

endmodule

// File: tb/tb_enc8to3_seq.sv
// Directed bench for enc8to3_seq: an LSB-first and an MSB-first instance share
// the same stimulus so both emission orders are checked on every vector.
module tb_enc8to3_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [7:0] in = 8'h00;
   logic       ready = 1'b0;

   logic [2:0] out0, out1;
   logic       valid0, valid1, last0, last1, busy0, busy1, zero0, zero1;
   logic [3:0] cnt0, cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   enc8to3_seq #(.MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .load(load), .in(in), .ready(ready),
      .out(out0), .valid(valid0), .last(last0), .busy(busy0), .zero(zero0), .cnt(cnt0)
   );

   enc8to3_seq #(.MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .load(load), .in(in), .ready(ready),
      .out(out1), .valid(valid1), .last(last1), .busy(busy1), .zero(zero1), .cnt(cnt1)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Both instances: valid, last, busy, cnt, zero, and each one's out.
   task automatic chk_all(input string tag, input logic v, input logic l, input logic b,
                          input logic [3:0] c, input logic z,
                          input logic [2:0] o_lsb, input logic [2:0] o_msb);
      chk({tag, ".valid0"}, {7'd0, valid0}, {7'd0, v});
      chk({tag, ".valid1"}, {7'd0, valid1}, {7'd0, v});
      chk({tag, ".last0"},  {7'd0, last0},  {7'd0, l});
      chk({tag, ".last1"},  {7'd0, last1},  {7'd0, l});
      chk({tag, ".busy0"},  {7'd0, busy0},  {7'd0, b});
      chk({tag, ".busy1"},  {7'd0, busy1},  {7'd0, b});
      chk({tag, ".cnt0"},   {4'd0, cnt0},   {4'd0, c});
      chk({tag, ".cnt1"},   {4'd0, cnt1},   {4'd0, c});
      chk({tag, ".zero0"},  {7'd0, zero0},  {7'd0, z});
      chk({tag, ".zero1"},  {7'd0, zero1},  {7'd0, z});
      chk({tag, ".out0"},   {5'd0, out0},   {5'd0, o_lsb});
      chk({tag, ".out1"},   {5'd0, out1},   {5'd0, o_msb});
      $display("%0t %s: out0=%0d out1=%0d valid=%b last=%b busy=%b cnt=%0d zero=%b",
               $time, tag, out0, out1, valid0, last0, busy0, cnt0, zero0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      step();
      chk_all("reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0);
      rst = 1'b0;
      step();

      // 1: 1010_0100 -> 2,5,7 (LSB first) / 7,5,2 (MSB first)
      en = 1'b1; load = 1'b1; in = 8'b1010_0100; ready = 1'b1;
      step();
      load = 1'b0;
      chk_all("t1.c0", 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 3'd2, 3'd7);
      step();
      chk_all("t1.c1", 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 3'd5, 3'd5);
      step();
      chk_all("t1.c2", 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 3'd7, 3'd2);
      step();
      chk_all("t1.done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd7, 3'd2);

      // 2: 8'hFF drains in 8 cycles, then an immediate new load of 8'h01
      load = 1'b1; in = 8'hFF;
      step();
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk_all($sformatf("t2.c%0d", i), 1'b1, (i == 7), 1'b1, 4'(8 - i), 1'b0,
                 3'(i), 3'(7 - i));
         step();
      end
      chk_all("t2.done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd7, 3'd0);
      load = 1'b1; in = 8'h01;
      step();
      load = 1'b0;
      chk_all("t2.one", 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 3'd0, 3'd0);
      step();
      chk_all("t2.idle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0);

      // 3: empty vector gives a one-cycle zero pulse
      load = 1'b1; in = 8'h00;
      step();
      load = 1'b0;
      chk_all("t3.zero", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 3'd0, 3'd0);
      step();
      chk_all("t3.after", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0);

      // 4: back-pressure via ready, then pause via en
      ready = 1'b0; load = 1'b1; in = 8'b0001_0010;
      step();
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_all($sformatf("t4.hold%0d", i), 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 3'd1, 3'd4);
         step();
      end
      en = 1'b0; ready = 1'b1;
      #1;
      chk_all("t4.pause0", 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 3'd1, 3'd4);
      step();
      step();
      chk_all("t4.pause2", 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 3'd1, 3'd4);
      en = 1'b1;
      #1;
      chk_all("t4.resume", 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 3'd1, 3'd4);
      step();
      chk_all("t4.second", 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 3'd4, 3'd1);
      step();
      chk_all("t4.idle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd4, 3'd1);

      // 5: loads while sending are ignored, including on the final handshake
      load = 1'b1; in = 8'h81;
      step();
      in = 8'h7E;
      chk_all("t5.first", 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 3'd0, 3'd7);
      step();
      chk_all("t5.second", 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 3'd7, 3'd0);
      step();
      load = 1'b0;
      chk_all("t5.idle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd7, 3'd0);
      step();

      // 6: asynchronous reset mid-transfer, then a fresh load
      load = 1'b1; in = 8'h0F;
      step();
      load = 1'b0;
      chk_all("t6.first", 1'b1, 1'b0, 1'b1, 4'd4, 1'b0, 3'd0, 3'd3);
      step();
      chk_all("t6.second", 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 3'd1, 3'd2);
      #2;
      rst = 1'b1;
      #1;
      chk_all("t6.rst", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0);
      step();
      rst = 1'b0;
      load = 1'b1; in = 8'h40;
      step();
      load = 1'b0;
      chk_all("t6.reload", 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 3'd6, 3'd6);
      step();
      chk_all("t6.idle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd6, 3'd6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
